// File: rtl/pic_ctrl_pkg.sv
// pic_ctrl_pkg: register offsets, FSM encodings and helpers shared by the PIC.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package pic_ctrl_pkg;

  localparam int PIC_NSRC = 6;

  // Register offsets from BASE_ADDR (word-addressed window).
  localparam logic [31:0] REG_MODE = 32'h0000_0000;
  localparam logic [31:0] REG_MASK = 32'h0000_0004;
  localparam logic [31:0] REG_PEND = 32'h0000_0008;
  localparam logic [31:0] REG_ACK  = 32'h0000_000C;
  localparam logic [31:0] REG_STAT = 32'h0000_0010;

  // In-service index reported when nothing is being serviced.
  localparam logic [2:0] NO_SRC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GAP   = 2'd2
  } pic_state_t;

  // Fixed priority: lowest set index wins; NO_SRC when the vector is empty.
  function automatic logic [2:0] prio_enc(input logic [PIC_NSRC-1:0] v);
    logic [2:0] r;
    r = NO_SRC;
    for (int i = PIC_NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [PIC_NSRC-1:0] onehot(input logic [2:0] idx);
    logic [PIC_NSRC-1:0] r;
    r = '0;
    for (int i = 0; i < PIC_NSRC; i++) begin
      if (idx == 3'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_ctrl_sync.sv
// irq_sync_edge: 2-flop synchroniser for one async interrupt line plus rising-edge detect.
// Latency: lvl follows irq two edges after it is sampled; rise pulses for one cycle.
// Backpressure: none; free-running sampler.
// Ports: clk, reset (sync, active-high), irq (async in), lvl (synchronised level), rise (edge pulse).
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic lvl,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/pic_ctrl.sv
// pic_ctrl: programmable interrupt controller feeding CP0 HWInt, one serviced source at a time.
// Latency: level irq -> hwint_out in 2 edges, edge irq in 3; ACK drops hwint_out on the write edge.
// Backpressure: none on the bus; new requests wait in PEND until the current service ends.
// Ports: clk, reset (sync, active-high), irq_in[5:0] (async), addr/we/wdata (MMIO write),
//        rdata (combinational read), hwint_out (registered one-hot or zero), busy (registered).
module pic_ctrl
  import pic_ctrl_pkg::*;
#(
  parameter int          NSRC      = PIC_NSRC,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hwint_out,
  output logic            busy
);

  logic [NSRC-1:0] lvl;
  logic [NSRC-1:0] rise;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq_in[g]),
      .lvl   (lvl[g]),
      .rise  (rise[g])
    );
  end

  // Address decode
  logic sel_mode, sel_mask, sel_pend, sel_ack, sel_stat;
  assign sel_mode = (addr == BASE_ADDR + REG_MODE);
  assign sel_mask = (addr == BASE_ADDR + REG_MASK);
  assign sel_pend = (addr == BASE_ADDR + REG_PEND);
  assign sel_ack  = (addr == BASE_ADDR + REG_ACK);
  assign sel_stat = (addr == BASE_ADDR + REG_STAT);

  logic wr_mode, wr_mask, wr_pend, wr_ack;
  assign wr_mode = we & sel_mode;
  assign wr_mask = we & sel_mask;
  assign wr_pend = we & sel_pend;
  assign wr_ack  = we & sel_ack;

  logic [2:0]      ack_idx;
  logic [NSRC-1:0] wbits;
  assign ack_idx = wdata[2:0];
  assign wbits   = wdata[NSRC-1:0];

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:NSRC]};

  // Configuration and pending state
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] latch;
  logic [NSRC-1:0] latch_clr;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] elig;
  logic [2:0]      win;

  // ACK of an index clears that latch whether or not it is the one in service.
  assign latch_clr = (wr_pend ? wbits : '0) | (wr_ack ? onehot(ack_idx) : '0);

  // Only edge-mode lines latch; a level line flipped to edge mode starts clean.
  assign pend = (mode & latch) | (~mode & lvl);
  assign elig = pend & mask;
  assign win  = prio_enc(elig);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode  <= '0;
      mask  <= '0;
      latch <= '0;
    end else begin
      if (wr_mode) mode <= wbits;
      if (wr_mask) mask <= wbits;
      // Set is ORed in after the clear so a same-cycle edge is never lost.
      latch <= (latch & ~latch_clr) | (rise & mode);
    end
  end

  // Service FSM
  pic_state_t      state, state_d;
  logic [2:0]      isr_idx, isr_idx_d;
  logic [NSRC-1:0] hwint_d;
  logic            busy_d;
  logic            end_service;

  // hwint_out is one-hot(isr_idx) while serving, so a mask write that clears
  // that bit is detected without indexing wdata by isr_idx.
  assign end_service = (wr_ack && (ack_idx == isr_idx)) ||
                       (wr_mask && ((wbits & hwint_out) == '0));

  always_comb begin
    state_d   = state;
    isr_idx_d = isr_idx;
    hwint_d   = hwint_out;
    busy_d    = busy;
    case (state)
      ST_IDLE: begin
        if (|elig) begin
          state_d   = ST_SERVE;
          isr_idx_d = win;
          hwint_d   = onehot(win);
          busy_d    = 1'b1;
        end
      end
      ST_SERVE: begin
        if (end_service) begin
          state_d   = ST_GAP;
          isr_idx_d = NO_SRC;
          hwint_d   = '0;
          busy_d    = 1'b0;
        end
      end
      ST_GAP: begin
        // Guaranteed low cycle so CP0 sees a deassertion between services.
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        isr_idx_d = NO_SRC;
        hwint_d   = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      isr_idx   <= NO_SRC;
      hwint_out <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      isr_idx   <= isr_idx_d;
      hwint_out <= hwint_d;
      busy      <= busy_d;
    end
  end

  // Read mux
  always_comb begin
    rdata = 32'h0;
    if (sel_mode)      rdata = {{(32-NSRC){1'b0}}, mode};
    else if (sel_mask) rdata = {{(32-NSRC){1'b0}}, mask};
    else if (sel_pend) rdata = {{(32-NSRC){1'b0}}, pend};
    else if (sel_stat) rdata = {busy, 25'b0, isr_idx, 3'b000};
  end

endmodule

// File: doc/pic_ctrl.md
# pic_ctrl

Programmable interrupt controller between the external device interrupt lines and the CP0 hardware-interrupt input. It synchronises six asynchronous sources and latches edge-triggered ones. It arbitrates by fixed priority and presents exactly one serviced source at a time on `hwint_out`. Software configures and acknowledges it through a word-addressed MMIO window on the bridge bus.

## Interface
- `NSRC`, 6: number of interrupt sources; fixed to CP0 HWInt width.
- `BASE_ADDR`, 32'h0000_7F20: byte address of register 0.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `irq_in`  in  6  asynchronous device interrupt lines, active-high.
- `addr`  in  32  bus byte address, word-aligned.
- `we`  in  1  bus write strobe, one cycle per write.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  bus read data, combinational from `addr`.
- `hwint_out`  out  6  one-hot (or zero) vector to CP0 HWInt.
- `busy`  out  1  high while a source is in service.

## Operation
- Register map, offsets from BASE_ADDR:
  - 0x00 MODE: rw, bits[5:0]. 1 = edge, 0 = level.
  - 0x04 MASK: rw, bits[5:0]. 1 = enabled.
  - 0x08 PEND: reads the effective pending vector. A write clears the latched edge bits where `wdata` = 1.
  - 0x0C ACK: wo. `wdata[2:0]` = source index.
  - 0x10 STAT: ro. `{busy, 25'b0, in-service index[2:0] or 3'b111, 3'b0}`.
- Unmapped reads return 0. Unmapped writes, and writes to STAT, are ignored.
- Sync: 2-flop synchroniser per line giving `s2`, plus a delay flop `s3`. Rising edge = `s2 & ~s3`.
- Pending:
  - Edge source: latch bit set on a rising edge. Cleared by a PEND W1C write or by an ACK of that index. Set wins over a same-cycle clear.
  - Level source: pending = `s2`, with no latch.
  - Changing MODE does not clear the latch.
- Eligible = pending & MASK. Priority is fixed: lowest index wins.
- FSM:
  - IDLE: if any source is eligible, capture the winner index, go to SERVE, and drive `hwint_out` = one-hot(winner).
  - SERVE: hold `hwint_out`.
    - An ACK write of the in-service index goes to GAP and clears `hwint_out`.
    - Masking the in-service source (MASK write) has the same effect, and also goes to GAP.
    - An ACK with any other index is ignored.
  - GAP: one cycle with `hwint_out` = 0, then IDLE. This guarantees CP0 sees a deassertion between services.
- A source becoming eligible while another is in service waits, regardless of priority. There is no pre-emption.
- Level source deasserting during SERVE: `hwint_out` stays asserted until ACK. Software must tolerate spurious service.

## Timing
- Reset values:
  - `hwint_out` = 0, `busy` = 0.
  - MODE = 0, MASK = 0, PEND latches = 0, sync flops = 0.
  - FSM in IDLE, in-service index = 3'b111.
- `hwint_out` and `busy` are registered outputs.
- Level-source latency: `irq_in` high sampled at edge N, then `s2` at N+1, then `hwint_out` at N+2.
- Edge-source latency: latch set at N+2, then `hwint_out` at N+3.
- ACK write at edge M: `hwint_out` = 0 at M. IDLE is reached at M+1, and the earliest next assertion is at M+2.
- Register writes take effect at the write edge. `rdata` reflects state combinationally in the same cycle.
- Reset asserted mid-SERVE: `hwint_out` = 0 after the reset edge, and all latched pending bits are lost.

## Structure
- Shared package: register offsets, MODE/MASK/PEND/ACK/STAT macros, FSM state encodings (IDLE/SERVE/GAP) and the "no source" index 3'b111. These go alongside existing CP0 address macros in MACRO.v.
- One natural sub-module, `irq_sync_edge`: the per-line 2-flop synchroniser plus edge detector, instantiated 6 times.
- Priority encoder, FSM and register file stay in `pic_ctrl`.

## Test plan
- Setup: MASK=0x3F, MODE=0. Raise `irq_in`=6'b000100 at edge 0.
  - Required: `hwint_out`=6'b000100 at edge 2.
  - Then ACK=2 gives `hwint_out`=0 on the ACK edge and again 6'b000100 two cycles later (level still high).
- Setup: MODE=0x3F, MASK=0x3F. Pulse `irq_in[5]` for one cycle.
  - Required: PEND reads 0x20 and `hwint_out`=6'b100000 at edge 3.
  - Then ACK=5 gives PEND=0 and `hwint_out` stays 0.
- Raise `irq_in[1]` and `irq_in[4]` together, all level.
  - Required: source 1 is served first. After ACK=1, a GAP cycle follows, then `hwint_out`=6'b010000.
- In SERVE on source 3, write ACK=0.
  - Required: ignored, `hwint_out` stays 6'b001000 and STAT index = 3.
- Edge source 0: a rising edge and a PEND W1C of bit 0 in the same cycle.
  - Required: PEND bit 0 remains 1.
- Assert `reset` while in SERVE.
  - Required: `hwint_out`=0, `busy`=0, MASK=0 and STAT index=7 after the reset edge. No reassertion occurs until MASK is rewritten.
